// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: UART RX frame checker (start, DATA_W data bits LSB-first, optional parity, STOP_BITS stops)
// Ports: CLK clock, RST async active-low reset; in: frame_start, sampled_bit, edge_cnt, Prescale, PAR_EN, PAR_TYP;
//        out: P_DATA, data_valid, strt_glitch, par_err, stp_err, busy; err_cnt (8b) only with FRAME_ERR_CNT_EN defined.
module uart_rx_frame_chk #(
  parameter int DATA_W    = 8,
  parameter int PRESC_W   = 6,
  parameter int STOP_BITS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               frame_start,
  input  logic               sampled_bit,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               strt_glitch,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy
`ifdef FRAME_ERR_CNT_EN
  ,output logic [7:0]        err_cnt
`endif
);
  localparam int IW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t st, nxt;
  logic [PRESC_W-1:0] p_lat;
  logic pen, ptyp, stop_idx;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0] bit_idx;
  logic cp_hit, be_hit, last_bit, last_stop, accept, good;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      st   <= IDLE;
      busy <= 1'b0;
    end else begin
      st   <= nxt;
      busy <= nxt != IDLE;
    end
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = frame_start ? START : IDLE;
      START:   nxt = cp_hit && sampled_bit ? IDLE : be_hit ? DATA : START;
      DATA:    nxt = be_hit && last_bit ? (pen ? PARITY : STOP) : DATA;
      PARITY:  nxt = be_hit ? STOP : PARITY;
      STOP:    nxt = cp_hit && last_stop ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // check point is computed one bit wider so (P>>1)+2 never wraps
  always_comb begin
    cp_hit    = {1'b0, edge_cnt} == {1'b0, p_lat >> 1} + (PRESC_W+1)'(2);
    be_hit    = edge_cnt == p_lat - PRESC_W'(1);
    last_bit  = bit_idx == IW'(DATA_W-1);
    last_stop = int'(stop_idx) == STOP_BITS-1;
    accept    = st == IDLE && frame_start;
    good      = st == STOP && cp_hit && last_stop && sampled_bit && !par_err && !stp_err;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      p_lat       <= '0;
      pen         <= 1'b0;
      ptyp        <= 1'b0;
      shift       <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= good;
      if (good) P_DATA <= shift;
      if (accept) begin
        p_lat       <= Prescale < PRESC_W'(4) ? PRESC_W'(4) : Prescale;
        pen         <= PAR_EN;
        ptyp        <= PAR_TYP;
        bit_idx     <= '0;
        stop_idx    <= 1'b0;
        strt_glitch <= 1'b0;
        par_err     <= 1'b0;
        stp_err     <= 1'b0;
      end
      if (st == START && cp_hit && sampled_bit) strt_glitch <= 1'b1;
      if (st == DATA && cp_hit) shift <= {sampled_bit, shift[DATA_W-1:1]};
      if (st == DATA && be_hit) bit_idx <= bit_idx + IW'(1);
      if (st == PARITY && cp_hit) par_err <= sampled_bit ^ (^shift) ^ ptyp;
      if (st == STOP && cp_hit && !sampled_bit) stp_err <= 1'b1;
      if (st == STOP && be_hit && !last_stop) stop_idx <= 1'b1;
    end
`ifdef FRAME_ERR_CNT_EN
  logic frame_end;
  // flags settle on the edge the FSM reaches IDLE, so count one cycle later
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      frame_end <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_end <= st != IDLE && nxt == IDLE;
      if (frame_end && (strt_glitch || par_err || stp_err) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb_uart_rx_frame_chk: table-driven and randomized frame checks on 1- and 2-stop-bit instances
module tb_uart_rx_frame_chk;
  localparam int DW = 8;
  localparam int PW = 6;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  logic frame_start = 1'b0, sampled_bit = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [PW-1:0] edge_cnt = '0, Prescale = PW'(8);
  logic [DW-1:0] pd1, pd2;
  logic dv1, dv2, g1, g2, pe1, pe2, se1, se2, b1, b2;
`ifdef FRAME_ERR_CNT_EN
  logic [7:0] ec1, ec2;
`endif
  uart_rx_frame_chk #(.DATA_W(DW), .PRESC_W(PW), .STOP_BITS(1)) u1 (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .sampled_bit(sampled_bit), .edge_cnt(edge_cnt),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(pd1), .data_valid(dv1),
    .strt_glitch(g1), .par_err(pe1), .stp_err(se1), .busy(b1)
`ifdef FRAME_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );
  uart_rx_frame_chk #(.DATA_W(DW), .PRESC_W(PW), .STOP_BITS(2)) u2 (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .sampled_bit(sampled_bit), .edge_cnt(edge_cnt),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(pd2), .data_valid(dv2),
    .strt_glitch(g2), .par_err(pe2), .stp_err(se2), .busy(b2)
`ifdef FRAME_ERR_CNT_EN
    , .err_cnt(ec2)
`endif
  );
  typedef struct {
    logic [DW-1:0] d;
    bit pen, ptyp, parb, stb, s1, s2;
    int p;
    bit eg, ep, es1, es2, ev1, ev2;
  } vec_t;
  int checks = 0, failures = 0, dvc1 = 0, dvc2 = 0, m_ec1 = 0, m_ec2 = 0;
  logic [DW-1:0] m_pd1 = '0, m_pd2 = '0;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    if (dv1) dvc1++;
    if (dv2) dvc2++;
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit want = v.ptyp ? ~^v.d : ^v.d;
    r.eg = v.stb;
    r.ep = !v.stb && v.pen && (v.parb != want);
    r.es1 = !v.stb && !v.s1;
    r.es2 = !v.stb && (!v.s1 || !v.s2);
    r.ev1 = !v.stb && !r.ep && !r.es1;
    r.ev2 = !v.stb && !r.ep && !r.es2;
    return r;
  endfunction
  task automatic frame(input vec_t v, input bit fs_end);
    logic q[$];
    int cpb = v.p / 2 + 2;
    dvc1 = 0;
    dvc2 = 0;
    Prescale = PW'(v.p);
    PAR_EN = v.pen;
    PAR_TYP = v.ptyp;
    q.push_back(v.stb);
    if (!v.stb) begin
      for (int i = 0; i < DW; i++) q.push_back(v.d[i]);
      if (v.pen) q.push_back(v.parb);
      q.push_back(v.s1);
      q.push_back(v.s2);
    end
    for (int k = 0; k < q.size(); k++)
      for (int e = 0; e < v.p; e++) begin
        edge_cnt = e[PW-1:0];
        sampled_bit = (e == cpb) ? q[k] : 1'($urandom);
        frame_start = (k == 0 && e == 0) || (fs_end && k == q.size() - 2 && e == cpb) ||
                      (k >= 1 && k <= DW && $urandom_range(0, 15) == 0);
        tick();
        if (k == 0 && e == 0) begin
          Prescale = (v.p == 8) ? PW'(16) : PW'($urandom);
          PAR_EN = 1'($urandom);
          PAR_TYP = 1'($urandom);
          chk("accept1", {b1, g1, pe1, se1}, 4'b1000);
          chk("accept2", {b2, g2, pe2, se2}, 4'b1000);
        end
        if (k == 0 && e == cpb) begin
          chk("start_busy1", b1, !v.stb);
          chk("start_busy2", b2, !v.stb);
        end
        if (!v.stb && k == q.size() - 2 && e == cpb) chk("stop_dv1", {dv1, b1}, {v.ev1, 1'b0});
        if (!v.stb && k == q.size() - 1 && e == cpb) chk("stop_dv2", {dv2, b2}, {v.ev2, 1'b0});
      end
    frame_start = 1'b0;
    sampled_bit = 1'b1;
    edge_cnt = '0;
    repeat (3) tick();
    if (v.ev1) m_pd1 = v.d;
    if (v.ev2) m_pd2 = v.d;
    m_ec1 = (m_ec1 + int'(v.eg || v.ep || v.es1)) > 255 ? 255 : m_ec1 + int'(v.eg || v.ep || v.es1);
    m_ec2 = (m_ec2 + int'(v.eg || v.ep || v.es2)) > 255 ? 255 : m_ec2 + int'(v.eg || v.ep || v.es2);
    chk("flags1", {g1, pe1, se1, b1}, {v.eg, v.ep, v.es1, 1'b0});
    chk("flags2", {g2, pe2, se2, b2}, {v.eg, v.ep, v.es2, 1'b0});
    chk("pdata1", pd1, m_pd1);
    chk("pdata2", pd2, m_pd2);
    chk("dv_count1", dvc1, int'(v.ev1));
    chk("dv_count2", dvc2, int'(v.ev2));
`ifdef FRAME_ERR_CNT_EN
    chk("err_cnt1", ec1, m_ec1);
    chk("err_cnt2", ec2, m_ec2);
`endif
  endtask
  initial begin
    vec_t v;
    tbl[0] = '{8'hA5, 1, 0, 0, 0, 1, 1, 8,  0, 0, 0, 0, 1, 1};
    tbl[1] = '{8'h00, 0, 0, 0, 1, 1, 1, 8,  1, 0, 0, 0, 0, 0};
    tbl[2] = '{8'h01, 1, 1, 1, 0, 1, 1, 8,  0, 1, 0, 0, 0, 0};
    tbl[3] = '{8'h3C, 0, 0, 0, 0, 1, 0, 8,  0, 0, 0, 1, 1, 0};
    tbl[4] = '{8'h5A, 0, 0, 0, 0, 1, 1, 16, 0, 0, 0, 0, 1, 1};
    tbl[5] = '{8'hFF, 1, 1, 1, 0, 1, 1, 8,  0, 0, 0, 0, 1, 1};
    tbl[6] = '{8'h00, 1, 0, 0, 0, 0, 1, 8,  0, 0, 1, 1, 0, 0};
    tbl[7] = '{8'h80, 1, 0, 1, 0, 1, 1, 16, 0, 0, 0, 0, 1, 1};
    repeat (3) tick();
    chk("reset1", {pd1, dv1, g1, pe1, se1, b1}, 0);
    chk("reset2", {pd2, dv2, g2, pe2, se2, b2}, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    for (int i = 0; i < 8; i++) frame(tbl[i], i == 4);
    Prescale = PW'(8);
    PAR_EN = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < 8; e++) begin
        edge_cnt = e[PW-1:0];
        sampled_bit = k != 0;
        frame_start = k == 0 && e == 0;
        tick();
        if (k == 0 && e == 0) Prescale = PW'(16);
      end
    chk("mid_busy", {b1, b2}, 2'b11);
    RST = 1'b0;
    #2;
    chk("rst_mid1", {pd1, dv1, g1, pe1, se1, b1}, 0);
    chk("rst_mid2", {pd2, dv2, g2, pe2, se2, b2}, 0);
`ifdef FRAME_ERR_CNT_EN
    chk("rst_mid_cnt", {ec1, ec2}, 0);
`endif
    frame_start = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    m_pd1 = '0;
    m_pd2 = '0;
    m_ec1 = 0;
    m_ec2 = 0;
    frame('{8'hC3, 1, 1, 1, 0, 1, 1, 8, 0, 0, 0, 0, 1, 1}, 0);
    for (int n = 0; n < 120; n++) begin
      v.d = DW'($urandom);
      v.pen = 1'($urandom);
      v.ptyp = 1'($urandom);
      v.parb = (v.ptyp ? ~^v.d : ^v.d) ^ ($urandom_range(0, 4) == 0);
      v.stb = $urandom_range(0, 9) == 0;
      v.s1 = $urandom_range(0, 7) != 0;
      v.s2 = $urandom_range(0, 7) != 0;
      v.p = $urandom_range(6, 20);
      frame(model(v), 1'($urandom));
    end
`ifdef FRAME_ERR_CNT_EN
    for (int n = 0; n < 260; n++) frame('{8'h00, 0, 0, 0, 1, 1, 1, 8, 1, 0, 0, 0, 0, 0}, 0);
    chk("err_cnt_sat1", ec1, 255);
    chk("err_cnt_sat2", ec2, 255);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
